// File: rtl/onehot_display_decoder.sv
// onehot_display_decoder
//
// Decoder end of the button code path. It accepts 3-bit codes over a
// valid/ready handshake and shows each one as a one-hot pattern on the LED or
// strobe lines for HOLD cycles. Each pattern is followed by GAP blank cycles.
// A one-entry pending slot lets the producer queue the next code while the
// current one is displayed.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous, active-high reset
//   code      0 = timed blank slot, 1..6 = line index + 1, 7 = illegal
//   in_valid  producer has a code on `code`
//   in_ready  pending slot is empty, so a code can be taken this cycle
//   b         registered display lines, all zero or exactly one line high
//   busy      a code is pending or a display/gap window is running
//   err       one-cycle pulse after a code 7 has been accepted
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing on display; loads the pending code if there is one
// SHOW  | pattern on b, counting down the HOLD window
// GAP   | b blank, counting down the GAP window before the next code

module onehot_display_decoder #(
    parameter int HOLD = 4,
    parameter int GAP  = 1,
    parameter int CW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [5:0] b,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_valid_q, pend_valid_d;
    logic [2:0]    pend_code_q, pend_code_d;
    logic [5:0]    b_q, b_d;
    logic          err_q, err_d;

    logic          accept;
    logic          load;

    // Code 7 never reaches the pending slot, so only 0..6 are decoded here.
    function automatic logic [5:0] onehot(input logic [2:0] c);
        logic [5:0] r;
        r = 6'b000000;
        case (c)
            3'd1:    r = 6'b000001;
            3'd2:    r = 6'b000010;
            3'd3:    r = 6'b000100;
            3'd4:    r = 6'b001000;
            3'd5:    r = 6'b010000;
            3'd6:    r = 6'b100000;
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= 3'd0;
            b_q          <= 6'b000000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            b_q          <= b_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        b_d          = b_q;
        err_d        = 1'b0;
        load         = 1'b0;

        // in_ready is !pend_valid_q, so an accept can never coincide with a
        // load: a load needs the slot full, an accept needs it empty.
        accept = in_valid && !pend_valid_q;

        case (state_q)
            S_IDLE: begin
                b_d = 6'b000000;
                if (pend_valid_q) begin
                    load = 1'b1;
                end
            end
            S_SHOW: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        b_d     = 6'b000000;
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end else if (pend_valid_q) begin
                        load = 1'b1;
                    end else begin
                        b_d     = 6'b000000;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                b_d = 6'b000000;
                if (cnt_q == '0) begin
                    if (pend_valid_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                b_d     = 6'b000000;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            b_d          = onehot(pend_code_q);
            cnt_d        = HOLD_LD;
            state_d      = S_SHOW;
            pend_valid_d = 1'b0;
        end

        if (accept) begin
            if (code == 3'd7) begin
                err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_code_d  = code;
            end
        end
    end

    // Outputs, from registered state only
    always_comb begin
        in_ready = !pend_valid_q;
        busy     = (state_q != S_IDLE) || pend_valid_q;
        b        = b_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_onehot_display_decoder.sv
// Testbench for onehot_display_decoder (HOLD=4, GAP=1).
// Each step drives inputs shortly after a rising edge and queues the outputs
// expected for that cycle; a monitor samples on the falling edge, pops the
// queue and compares.

module tb_onehot_display_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] code;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] b;
    logic       busy;
    logic       err;

    typedef struct packed {
        logic [5:0] b;
        logic       busy;
        logic       rdy;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    onehot_display_decoder #(.HOLD(4), .GAP(1), .CW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .code     (code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .b        (b),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor / checker
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (b !== e.b) begin
                errors = errors + 1;
                $display("FAIL b cycle %0d: got %b expected %b", cyc, b, e.b);
            end
            checks = checks + 1;
            if (busy !== e.busy) begin
                errors = errors + 1;
                $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, e.busy);
            end
            checks = checks + 1;
            if (in_ready !== e.rdy) begin
                errors = errors + 1;
                $display("FAIL in_ready cycle %0d: got %b expected %b", cyc, in_ready, e.rdy);
            end
            checks = checks + 1;
            if (err !== e.err) begin
                errors = errors + 1;
                $display("FAIL err cycle %0d: got %b expected %b", cyc, err, e.err);
            end
            checks = checks + 1;
            if (!(b == 6'b0 || $onehot(b))) begin
                errors = errors + 1;
                $display("FAIL onehot cycle %0d: got %b expected zero or one-hot", cyc, b);
            end
        end
    end

    // Queue the outputs expected after this edge, then drive the inputs that
    // the next edge will sample.
    task automatic step(input logic r, input logic v, input logic [2:0] c,
                        input logic [5:0] eb, input logic ebusy,
                        input logic erdy, input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        e.b    = eb;
        e.busy = ebusy;
        e.rdy  = erdy;
        e.err  = eerr;
        exp_q.push_back(e);
        rst      = r;
        in_valid = v;
        code     = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        code     = 3'd0;

        // Reset held for two edges, then quiet for ten cycles
        step(1'b1, 1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b0);
        idle(10);

        // Single code 3
        step(1'b0, 1'b1, 3'd3, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd0, 6'b000100, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Back-to-back codes 1 then 6
        step(1'b0, 1'b1, 3'd1, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd6, 6'b000000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd6, 6'b000001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 6'b000001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd0, 6'b100000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Illegal code 7: one err pulse, display and busy untouched
        step(1'b0, 1'b1, 3'd7, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Blank code 0: full timed slot with b held at zero
        step(1'b0, 1'b1, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Backpressure: 2, 4, 5 with in_valid held until each is taken
        step(1'b0, 1'b1, 3'd2, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd4, 6'b000000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 6'b000010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd5, 6'b000010, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 6'b000000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 6'b001000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 6'b001000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd0, 6'b010000, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Reset during SHOW with code 2 pending: code 2 must never appear
        step(1'b0, 1'b1, 3'd1, 6'b000000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd2, 6'b000000, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 6'b000001, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 6'b000001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 6'b000000, 1'b0, 1'b1, 1'b0);
        idle(10);

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
